// File: rtl/apb_master_ctrl.sv
// APB master controller: queues read/write commands in a small FIFO and runs
// them one at a time as APB transfers, returning one response per command.
module apb_master_ctrl #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 21,
   parameter int CMD_DEPTH = 4,
   parameter int TIMEOUT   = 15
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic              PREADY,
   input  logic              PSLVERR,
   input  logic [DATA_W-1:0] PRDATA
);

   localparam int PTR_W = $clog2(CMD_DEPTH);
   localparam int CMD_W = 1 + ADDR_W + DATA_W;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CMD_W-1:0]    fifo_mem_q [CMD_DEPTH];
   logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
   logic                empty_s, full_s, push_s, pop_s;
   logic                head_write_s;
   logic [ADDR_W-1:0]   head_addr_s;
   logic [DATA_W-1:0]   head_wdata_s;
   logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

   // The extra pointer MSB tells a full FIFO apart from an empty one.
   assign empty_s   = (wr_ptr_q == rd_ptr_q);
   assign full_s    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign req_ready = !full_s;
   assign push_s    = req_valid && !full_s;
   assign {head_write_s, head_addr_s, head_wdata_s} = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

   // Command storage; contents are only meaningful between the pointers.
   always_ff @(posedge PCLK) begin
      if (push_s) begin
         fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {req_write, req_addr, req_wdata};
      end
   end

   // FIFO pointer next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Transfer FSM next-state and registered APB/response outputs.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      pop_s       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            if (!empty_s) begin
               pop_s = 1'b1;
            end else begin
               pop_s = 1'b0;
            end
         end
         ST_SETUP: begin
            penable_d  = 1'b1;
            wait_cnt_d = '0;
            state_d    = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
               rsp_err_d   = PSLVERR;
               state_d     = ST_RESP;
            end else if ((TIMEOUT != 0) && (wait_cnt_q == TO_LAST)) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               state_d     = ST_RESP;
            end else begin
               wait_cnt_d  = wait_cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
               pop_s       = !empty_s;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase

      // Launching a command always overrides the idle/return path above.
      if (pop_s) begin
         paddr_d    = head_addr_s;
         pwrite_d   = head_write_s;
         pwdata_d   = head_wdata_s;
         psel_d     = 1'b1;
         penable_d  = 1'b0;
         wait_cnt_d = '0;
         state_d    = ST_SETUP;
      end else begin
         paddr_d    = paddr_d;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         wait_cnt_q  <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         wait_cnt_q  <= wait_cnt_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed self-checking bench for apb_master_ctrl; the bench plays the APB slave.
module tb_apb_master_ctrl;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [7:0]  req_addr = 8'h00;
   logic [20:0] req_wdata = 21'h0;
   logic        rsp_ready = 1'b0;
   logic        PREADY = 1'b1;
   logic        PSLVERR = 1'b0;
   logic        prdata_mode = 1'b0;
   logic [20:0] prdata_fix = 21'h0;
   logic        req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE;
   logic [20:0] rsp_rdata, PWDATA, PRDATA;
   logic [7:0]  PADDR;
   int          checks = 0;
   int          errors = 0;

   // Slave read data: fixed value, or address-derived so drain order is visible.
   assign PRDATA = prdata_mode ? (21'(PADDR) + 21'h000100) : prdata_fix;

   apb_master_ctrl dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
   );

   always #5 PCLK = ~PCLK;

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic wait_rsp(input string name);
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_wait: rsp_valid=%b required 1 within 50 cycles", name, rsp_valid);
      end
   endtask

   task automatic pulse_rsp();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      PRESET = 1'b0;
      #3;
      checks++;
      if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, req_ready} !== 6'b000001 ||
          PADDR !== 8'h00 || PWDATA !== 21'h0 || rsp_rdata !== 21'h0) begin
         errors++;
         $display("FAIL reset_state: sel/en/wr/vld/err/rdy=%b addr=%h wdata=%h rdata=%h required 000001 0 0 0",
                  {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, req_ready}, PADDR, PWDATA, rsp_rdata);
      end
      @(negedge PCLK);
      PRESET = 1'b1;
   endtask

   task automatic test_write();
      PREADY = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 21'h0000AC;
      tick();
      req_valid = 1'b0;
      checks++;
      if (PSEL !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL write_edge1: PSEL=%b rsp_valid=%b required 0 0", PSEL, rsp_valid);
      end
      tick();
      checks++;
      if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 8'h10 || PWDATA !== 21'h0000AC) begin
         errors++;
         $display("FAIL write_setup: sel/en/wr=%b addr=%h wdata=%h required 101 10 0000ac",
                  {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
      end
      tick();
      checks++;
      if ({PSEL, PENABLE, rsp_valid} !== 3'b110 || PWDATA !== 21'h0000AC) begin
         errors++;
         $display("FAIL write_access: sel/en/vld=%b wdata=%h required 110 0000ac",
                  {PSEL, PENABLE, rsp_valid}, PWDATA);
      end
      tick();
      checks++;
      if ({PSEL, PENABLE, rsp_valid, rsp_err} !== 4'b0010 || rsp_rdata !== 21'h0) begin
         errors++;
         $display("FAIL write_resp: sel/en/vld/err=%b rdata=%h required 0010 0",
                  {PSEL, PENABLE, rsp_valid, rsp_err}, rsp_rdata);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL write_resp_hold: rsp_valid=%b required 1", rsp_valid);
      end
      pulse_rsp();
      checks++;
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0 || PADDR !== 8'h10 || PWDATA !== 21'h0000AC) begin
         errors++;
         $display("FAIL write_retain: vld=%b sel=%b addr=%h wdata=%h required 0 0 10 0000ac",
                  rsp_valid, PSEL, PADDR, PWDATA);
      end
   endtask

   task automatic test_read_wait();
      int acc = 0;
      PREADY = 1'b0; prdata_fix = 21'h0000AA;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h11;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         if (PENABLE === 1'b1) acc++;
         tick();
      end
      PREADY = 1'b1;
      if (PENABLE === 1'b1) acc++;
      tick();
      checks++;
      if (acc !== 4 || rsp_valid !== 1'b1 || rsp_rdata !== 21'h0000AA || rsp_err !== 1'b0 || PENABLE !== 1'b0) begin
         errors++;
         $display("FAIL read_wait: access=%0d vld=%b rdata=%h err=%b en=%b required 4 1 0000aa 0 0",
                  acc, rsp_valid, rsp_rdata, rsp_err, PENABLE);
      end
      pulse_rsp();
   endtask

   task automatic test_timeout();
      int acc = 0;
      PREADY = 1'b0; prdata_fix = 21'h000055;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h12;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      while (PENABLE === 1'b1 && acc < 40) begin
         acc++;
         tick();
      end
      checks++;
      if (acc !== 15 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 21'h0 || PSEL !== 1'b0) begin
         errors++;
         $display("FAIL timeout: access=%0d vld=%b err=%b rdata=%h sel=%b required 15 1 1 0 0",
                  acc, rsp_valid, rsp_err, rsp_rdata, PSEL);
      end
      PREADY = 1'b1;
      pulse_rsp();
   endtask

   task automatic test_back_to_back();
      int seen = 0;
      PREADY = 1'b1; prdata_mode = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h0F; req_wdata = 21'h000003;
      tick();
      req_valid = 1'b0;
      wait_rsp("b2b_hold");
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; req_write = 1'b0; req_addr = 8'(8'h10 + i);
         checks++;
         if (req_ready !== (i < 4)) begin
            errors++;
            $display("FAIL b2b_ready%0d: req_ready=%b required %0d", i, req_ready, (i < 4));
         end
         tick();
      end
      req_valid = 1'b0;
      checks++;
      if (rsp_rdata !== 21'h0 || rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: vld=%b rdata=%h required 1 0", rsp_valid, rsp_rdata);
      end
      pulse_rsp();
      for (int i = 0; i < 4; i++) begin
         wait_rsp("b2b_drain");
         checks++;
         if (rsp_rdata !== 21'(21'h000110 + i)) begin
            errors++;
            $display("FAIL b2b_order%0d: rdata=%h required %h", i, rsp_rdata, 21'(21'h000110 + i));
         end
         pulse_rsp();
      end
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid === 1'b1 || PSEL === 1'b1) seen++;
         tick();
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL b2b_extra: busy cycles=%0d required 0", seen);
      end
      prdata_mode = 1'b0;
   endtask

   task automatic test_slverr();
      PREADY = 1'b1; PSLVERR = 1'b1; prdata_fix = 21'h000077;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 21'h000001;
      tick();
      req_write = 1'b0; req_addr = 8'h21;
      tick();
      req_valid = 1'b0;
      wait_rsp("slverr_first");
      checks++;
      if (rsp_err !== 1'b1 || rsp_rdata !== 21'h0) begin
         errors++;
         $display("FAIL slverr_resp: err=%b rdata=%h required 1 0", rsp_err, rsp_rdata);
      end
      PSLVERR = 1'b0;
      pulse_rsp();
      checks++;
      if ({PSEL, PENABLE, PWRITE} !== 3'b100 || PADDR !== 8'h21 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL slverr_next_setup: sel/en/wr=%b addr=%h vld=%b required 100 21 0",
                  {PSEL, PENABLE, PWRITE}, PADDR, rsp_valid);
      end
      wait_rsp("slverr_second");
      checks++;
      if (rsp_err !== 1'b0 || rsp_rdata !== 21'h000077) begin
         errors++;
         $display("FAIL slverr_next_resp: err=%b rdata=%h required 0 000077", rsp_err, rsp_rdata);
      end
      pulse_rsp();
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      PREADY = 1'b0; rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1; req_write = 1'b0; req_addr = 8'(8'h30 + i);
         tick();
      end
      req_valid = 1'b0;
      tick();
      tick();
      checks++;
      if ({PSEL, PENABLE} !== 2'b11 || PADDR !== 8'h30) begin
         errors++;
         $display("FAIL rstmid_access: sel/en=%b addr=%h required 11 30", {PSEL, PENABLE}, PADDR);
      end
      #2;
      PRESET = 1'b0;
      #1;
      checks++;
      if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, req_ready} !== 6'b000001 ||
          PADDR !== 8'h00 || PWDATA !== 21'h0 || rsp_rdata !== 21'h0) begin
         errors++;
         $display("FAIL rstmid_async: sel/en/wr/vld/err/rdy=%b addr=%h wdata=%h rdata=%h required 000001 0 0 0",
                  {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, req_ready}, PADDR, PWDATA, rsp_rdata);
      end
      @(negedge PCLK);
      PRESET = 1'b1;
      PREADY = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rsp_valid === 1'b1 || PSEL === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL rstmid_flushed: busy cycles=%0d required 0", seen);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_timeout();
      test_back_to_back();
      test_slverr();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
